// File: rtl/dmem_responder.sv
// Data-memory responder: one RV32I load/store at a time, WAIT_STATES cycles of latency, one held response per access.
// Optional DMEM_MISALIGN_TRAP_EN: fault misaligned H/W accesses instead of force-aligning them.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept, exec, do_write;
    logic          ex_we;
    logic [2:0]    ex_f3;
    logic [31:0]   ex_addr, ex_wdata;
    logic [1:0]    off, eff_off;
    logic          bad_f3, oob, err;
    logic [AW-1:0] idx;
    logic [31:0]   word, shifted, load_val, wr_dat;
    logic [3:0]    be;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access executes on the accept edge, so it must see the live request.
    assign ex_we    = accept ? req_we     : we_q;
    assign ex_f3    = accept ? req_funct3 : f3_q;
    assign ex_addr  = accept ? req_addr   : addr_q;
    assign ex_wdata = accept ? req_wdata  : wdata_q;
    assign exec     = (state_d == RESP) && (state_q != RESP);

    assign off    = ex_addr[1:0];
    assign bad_f3 = (ex_f3 == 3'd3) || (ex_f3[2:1] == 2'b11) || (ex_we && ex_f3[2]);
    assign oob    = {2'b00, ex_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign idx    = ex_addr[AW+1:2];
    assign word   = mem[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign eff_off = off;
    assign err     = bad_f3 || oob ||
                     ((ex_f3[1:0] == 2'd1) && off[0]) ||
                     ((ex_f3[1:0] == 2'd2) && (off != 2'd0));
`else
    assign eff_off = (ex_f3[1:0] == 2'd2) ? 2'd0 :
                     (ex_f3[1:0] == 2'd1) ? {off[1], 1'b0} : off;
    assign err     = bad_f3 || oob;
`endif

    assign shifted = word >> {eff_off, 3'b000};

    always_comb begin
        load_val = 32'd0;
        wr_dat   = ex_wdata;
        be       = 4'b0000;
        case (ex_f3)
            3'd0: load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'd1: load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'd2: load_val = shifted;
            3'd4: load_val = {24'd0, shifted[7:0]};
            3'd5: load_val = {16'd0, shifted[15:0]};
            default: load_val = 32'd0;
        endcase
        case (ex_f3[1:0])
            2'd0: begin
                wr_dat = {4{ex_wdata[7:0]}};
                be     = 4'b0001 << eff_off;
            end
            2'd1: begin
                wr_dat = {2{ex_wdata[15:0]}};
                be     = eff_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_dat = ex_wdata;
                be     = 4'b1111;
            end
        endcase
        err_d   = err;
        rdata_d = (err || ex_we) ? 32'd0 : load_val;
    end

    assign do_write = exec && ex_we && !err && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (exec) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Storage has no reset; only the addressed byte lanes are touched.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters (DEPTH_WORDS=1024, WAIT_STATES=2).
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd;
    logic        er;

    dmem_responder dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int bp,
                        output logic [31:0] r, output logic e);
        int  lat;
        logic got;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = (bp == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            got = rsp_valid;
        end
        chk("latency", 32'(lat), 32'd3);
        r = 32'h0;
        e = 1'bx;
        if (got) begin
            r = rsp_rdata;
            e = rsp_err;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("bp_rdata", rsp_rdata, r);
                chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("ready_after_consume", {31'd0, req_ready}, 32'd1);
        end
        rsp_ready = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);

        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        chk("lw_10", rd, 32'hDEADBEEF);
        chk("lw_10_err", {31'd0, er}, 32'd0);

        xact(1'b0, 3'd0, 32'h13, 32'h0, 0, rd, er);
        chk("lb_13", rd, 32'hFFFFFFDE);
        xact(1'b0, 3'd4, 32'h13, 32'h0, 0, rd, er);
        chk("lbu_13", rd, 32'h000000DE);
        xact(1'b0, 3'd1, 32'h10, 32'h0, 0, rd, er);
        chk("lh_10", rd, 32'hFFFFBEEF);
        xact(1'b0, 3'd5, 32'h12, 32'h0, 0, rd, er);
        chk("lhu_12", rd, 32'h0000DEAD);

        xact(1'b1, 3'd0, 32'h11, 32'h00000055, 0, rd, er);
        xact(1'b1, 3'd1, 32'h12, 32'h00001234, 0, rd, er);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        chk("lw_after_sb_sh", rd, 32'h123455EF);

        xact(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er);
        chk("bp_lw", rd, 32'h123455EF);

        xact(1'b0, 3'd2, 32'h1000, 32'h0, 0, rd, er);
        chk("oob_err", {31'd0, er}, 32'd1);
        chk("oob_rdata", rd, 32'd0);
        xact(1'b0, 3'd3, 32'h10, 32'h0, 0, rd, er);
        chk("f3_3_err", {31'd0, er}, 32'd1);
        chk("f3_3_rdata", rd, 32'd0);
        xact(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 0, rd, er);
        chk("sbu_err", {31'd0, er}, 32'd1);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        chk("sbu_no_write", rd, 32'h123455EF);

        xact(1'b1, 3'd2, 32'h12, 32'hCAFEF00D, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_sw_err", {31'd0, er}, 32'd1);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        chk("mis_sw_mem", rd, 32'h123455EF);
        xact(1'b0, 3'd1, 32'h11, 32'h0, 0, rd, er);
        chk("mis_lh_err", {31'd0, er}, 32'd1);
        chk("mis_lh_rdata", rd, 32'd0);
`else
        chk("mis_sw_err", {31'd0, er}, 32'd0);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        chk("mis_sw_mem", rd, 32'hCAFEF00D);
        xact(1'b0, 3'd1, 32'h11, 32'h0, 0, rd, er);
        chk("mis_lh_err", {31'd0, er}, 32'd0);
        chk("mis_lh_rdata", rd, 32'hFFFFF00D);
`endif

        xact(1'b1, 3'd2, 32'h20, 32'h11223344, 0, rd, er);
        xact(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);
        chk("lw_20_pre", rd, 32'h11223344);

        // Abandon a store while it is still counting wait states.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h20;
        req_wdata  = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
        end
        xact(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);
        chk("lw_20_post", rd, 32'h11223344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
